dmux_stream: RTL and testbench
==============================

Name: dmux_stream

Overview:
- Parametrised 1-to-N streaming demultiplexer. It is the clocked successor of the combinational 1-to-4 demux.
- Routes each input beat to the output channel chosen by a select field, using valid/ready handshakes.
- Each channel has a one-entry output register, so a stalled channel never blocks beats bound for other channels.
- Sits between a single producer and N independent consumers.

Parameters:
- N_CH, 4, number of output channels (2..16).
- DW, 8, data width per beat.
- SW, $clog2(N_CH), select width. Derived localparam; not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid and in_ready are both high.
- in_data  input  DW  input payload.
- in_sel  input  SW  destination channel index.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  N_CH  per-channel valid.
- out_ready  input  N_CH  per-channel ready.
- out_data  output  N_CH*DW  channel k occupies bits [k*DW +: DW].
- out_last  output  N_CH  per-channel last flag.
- drop_err  output  1  one-cycle pulse when a beat with an out-of-range select is accepted.

Behaviour:
- Reset: asserting rst clears immediately, independent of clk. Afterwards out_valid=0, out_data=0, out_last=0, drop_err=0, and all channel buffers are empty.
- Reset mid-operation: buffered beats are discarded, and the lock state (if compiled in) returns to IDLE.
- Effective select (esel): equals in_sel, or lock_sel when locked (see Optional Feature).
- Channel full flag: full[k] == out_valid[k].
- in_ready = 1 if esel >= N_CH; otherwise in_ready = !full[esel] || out_ready[esel].
- in_ready depends combinationally on in_sel and out_ready. This path is intentional and documented.
- Accept to a valid channel k: on the next clk edge, out_data[k]/out_last[k] load in_data/in_last and out_valid[k]=1. Latency is 1 cycle.
- Accept with esel >= N_CH: the beat is discarded and drop_err=1 for exactly the next cycle. This only occurs when N_CH is not a power of two.
- Drain: when out_valid[k] && out_ready[k] and no new load to k, out_valid[k] goes to 0 at the next edge.
- Simultaneous drain and load on the same channel: the new beat replaces the old one and out_valid[k] stays 1. Full throughput is 1 beat/cycle.
- Stall: while out_valid[k] && !out_ready[k], out_data[k] and out_last[k] hold stable.
- Channel isolation: channels other than esel are never modified by an input accept.
- out_ready of an empty channel is ignored.
- in_valid low: no state change except draining.
- in_data and in_sel are don't-care when in_valid is low.

Optional Feature:
- Macro: DMUX_PKT_LOCK_EN.
- Defined: a 2-state FSM, IDLE / LOCKED.
  - IDLE: esel = in_sel. An accepted beat with in_last=0 sets lock_sel=in_sel and moves to LOCKED.
  - LOCKED: esel = lock_sel and in_sel is ignored. An accepted beat with in_last=1 returns to IDLE.
  - A single-beat packet (in_last=1 in IDLE) never locks.
  - A packet with an out-of-range select is dropped in its entirety, with one drop_err pulse per beat.
- Undefined: no FSM. esel = in_sel on every beat, and in_last is forwarded only.

Decomposition:
- Shared package/header dmux_pkg holds:
  - the lock-state encoding (ST_IDLE=0, ST_LOCKED=1);
  - the clog2-based select-width helper;
  - the channel-slice index helper.
- One sub-module: dmux_out_reg. It is a one-entry valid/ready buffer (clk, rst, load, data, last, out_valid, out_ready, out_data, out_last), instantiated N_CH times in a generate loop.
- The top level holds the select decode, in_ready mux, drop logic and optional FSM.

Test Plan:
- Reset then route (in_data=0xA5, in_sel=2, all out_ready=1):
  - out_valid=4'b0100 and out_data[2]=0xA5 one cycle after accept;
  - out_valid returns to 0 the cycle after that.
- Backpressure (out_ready[1]=0; send 0x11 then 0x22 to ch1):
  - 0x11 holds on out_data[1] and in_ready=0 for the second beat;
  - raising out_ready[1] accepts 0x22 in the same cycle;
  - back-to-back beats then flow at 1/cycle.
- Isolation (ch0 stalled full with 0x33; send 0x44 to ch3):
  - 0x44 is accepted immediately and ch0 still holds 0x33.
- Out-of-range (N_CH=3, in_sel=3, in_data=0x55):
  - in_ready=1, drop_err pulses for 1 cycle, and all out_valid stay 0.
- Async reset (rst pulsed between edges while ch0 and ch2 are full):
  - out_valid=0 immediately and stays 0 after rst deasserts until a new accept.
- Lock, DMUX_PKT_LOCK_EN defined (3-beat packet 0x01, 0x02, 0x03 with in_sel=1, 3, 0; last on beat 3):
  - all three beats appear on ch1 in order, and out_last[1]=1 only with 0x03;
  - a following single beat with in_sel=2 goes to ch2.

Source files
------------

// File: rtl/dmux_pkg.sv
// dmux_pkg: shared lock-state encoding and index helpers for dmux_stream
package dmux_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} lock_st_t;
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  function automatic int slice_lo(input int k, input int dw);
    return k * dw;
  endfunction
endpackage

// File: rtl/dmux_out_reg.sv
// dmux_out_reg: one-entry valid/ready output buffer for a single channel
module dmux_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] data,
  input  logic          last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);
  // a load wins over a drain so a same-cycle drain+load keeps the channel full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data;
      out_last  <= last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/dmux_stream.sv
// dmux_stream: 1-to-N_CH valid/ready demux; DMUX_PKT_LOCK_EN locks the select per packet
module dmux_stream
  import dmux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int DW   = 8,
  localparam int SW   = sel_w(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic [SW-1:0]      in_sel,
  input  logic               in_last,
  output logic [N_CH-1:0]    out_valid,
  input  logic [N_CH-1:0]    out_ready,
  output logic [N_CH*DW-1:0] out_data,
  output logic [N_CH-1:0]    out_last,
  output logic               drop_err
);
  logic [SW-1:0]   esel;
  logic            oor;
  logic            acc;
  logic [N_CH-1:0] load;
`ifdef DMUX_PKT_LOCK_EN
  lock_st_t      st;
  logic [SW-1:0] lock_sel;
  assign esel = (st == ST_LOCKED) ? lock_sel : in_sel;
  // first non-last beat of a packet pins the channel until its last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ST_IDLE;
      lock_sel <= '0;
    end else if (acc) begin
      if (st == ST_IDLE && !in_last) begin
        st       <= ST_LOCKED;
        lock_sel <= in_sel;
      end else if (st == ST_LOCKED && in_last) begin
        st <= ST_IDLE;
      end
    end
  end
`else
  assign esel = in_sel;
`endif
  assign oor      = int'(esel) >= N_CH;
  assign in_ready = oor || !out_valid[esel] || out_ready[esel];
  assign acc      = in_valid && in_ready;
  assign load     = (acc && !oor) ? (N_CH'(1) << esel) : '0;
  // out-of-range beats are swallowed and flagged for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_err <= 1'b0;
    else     drop_err <= acc && oor;
  end
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    dmux_out_reg #(.DW(DW)) u_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .data     (in_data),
      .last     (in_last),
      .out_valid(out_valid[k]),
      .out_ready(out_ready[k]),
      .out_data (out_data[slice_lo(k, DW) +: DW]),
      .out_last (out_last[k])
    );
  end
endmodule

// File: tb/tb_dmux_stream.sv
// tb_dmux_stream: vector table, corner sequences and random model check of dmux_stream
module tb_dmux_stream;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst;
  logic v, l, irdy, de;
  logic [1:0] sel;
  logic [7:0] d;
  logic [3:0] rdy, ov, ol;
  logic [31:0] od;
  logic v3, l3, irdy3, de3;
  logic [1:0] sel3;
  logic [7:0] d3;
  logic [2:0] rdy3, ov3, ol3;
  logic [23:0] od3;
  int pass = 0, total = 0;

  dmux_stream #(.N_CH(4), .DW(8)) u4 (
    .clk(clk), .rst(rst), .in_valid(v), .in_ready(irdy), .in_data(d), .in_sel(sel),
    .in_last(l), .out_valid(ov), .out_ready(rdy), .out_data(od), .out_last(ol), .drop_err(de));
  dmux_stream #(.N_CH(3), .DW(8)) u3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(irdy3), .in_data(d3), .in_sel(sel3),
    .in_last(l3), .out_valid(ov3), .out_ready(rdy3), .out_data(od3), .out_last(ol3), .drop_err(de3));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; v = 0; sel = 0; d = 0; l = 0; rdy = 0;
    v3 = 0; sel3 = 0; d3 = 0; l3 = 0; rdy3 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  typedef struct {
    logic v; logic [1:0] s; logic [7:0] d; logic [3:0] r;
    logic eir; logic [3:0] ev; int ch; logic [7:0] ed;
  } vec_t;
  vec_t tv[11];

  logic mv[4];
  logic [7:0] md[4];
  logic ml[4];
  logic locked;
  logic [1:0] lsel;

  initial begin
    tv[0]  = '{1, 2, 8'hA5, 4'b1111, 1, 4'b0100, 2, 8'hA5};
    tv[1]  = '{0, 0, 8'h00, 4'b1111, 1, 4'b0000, -1, 8'h00};
    tv[2]  = '{1, 1, 8'h11, 4'b1101, 1, 4'b0010, 1, 8'h11};
    tv[3]  = '{1, 1, 8'h22, 4'b1101, 0, 4'b0010, 1, 8'h11};
    tv[4]  = '{1, 1, 8'h22, 4'b1111, 1, 4'b0010, 1, 8'h22};
    tv[5]  = '{1, 1, 8'h23, 4'b1111, 1, 4'b0010, 1, 8'h23};
    tv[6]  = '{1, 0, 8'h33, 4'b1110, 1, 4'b0001, 0, 8'h33};
    tv[7]  = '{1, 3, 8'h44, 4'b1110, 1, 4'b1001, 3, 8'h44};
    tv[8]  = '{0, 0, 8'h00, 4'b0000, 0, 4'b1001, 0, 8'h33};
    tv[9]  = '{1, 0, 8'h66, 4'b0001, 1, 4'b1001, 0, 8'h66};
    tv[10] = '{0, 0, 8'h00, 4'b1111, 1, 4'b0000, -1, 8'h00};

    do_reset();
    chk("reset_valid", 32'(ov), 0);
    chk("reset_data", od, 0);
    chk("reset_last", 32'(ol), 0);
    chk("reset_drop", 32'(de), 0);

    for (int i = 0; i < 11; i++) begin
      v = tv[i].v; sel = tv[i].s; d = tv[i].d; l = 1; rdy = tv[i].r;
      #1 chk($sformatf("vec%0d_in_ready", i), 32'(irdy), 32'(tv[i].eir));
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(ov), 32'(tv[i].ev));
      if (tv[i].ch >= 0) begin
        chk($sformatf("vec%0d_data", i), 32'(od[tv[i].ch*8 +: 8]), 32'(tv[i].ed));
        chk($sformatf("vec%0d_last", i), 32'(ol[tv[i].ch]), 1);
      end
    end

    v = 1; l = 1; rdy = 0; sel = 0; d = 8'h77;
    tick();
    sel = 2; d = 8'h78;
    tick();
    v = 0;
    chk("pre_async_valid", 32'(ov), 32'b0101);
    #2 rst = 1;
    #1 chk("async_valid", 32'(ov), 0);
    chk("async_data", od, 0);
    #1 rst = 0;
    tick();
    chk("post_async_valid", 32'(ov), 0);

    rdy = 4'b1111; v = 1;
    sel = 1; d = 8'h01; l = 0;
    tick();
    chk("pkt_b1_valid", 32'(ov), 32'b0010);
    chk("pkt_b1_data", 32'(od[15:8]), 8'h01);
    chk("pkt_b1_last", 32'(ol[1]), 0);
    sel = 3; d = 8'h02; l = 0;
    tick();
`ifdef DMUX_PKT_LOCK_EN
    chk("pkt_b2_valid", 32'(ov), 32'b0010);
    chk("pkt_b2_data", 32'(od[15:8]), 8'h02);
    chk("pkt_b2_last", 32'(ol[1]), 0);
`else
    chk("pkt_b2_valid", 32'(ov), 32'b1000);
    chk("pkt_b2_data", 32'(od[31:24]), 8'h02);
`endif
    sel = 0; d = 8'h03; l = 1;
    tick();
`ifdef DMUX_PKT_LOCK_EN
    chk("pkt_b3_valid", 32'(ov), 32'b0010);
    chk("pkt_b3_data", 32'(od[15:8]), 8'h03);
    chk("pkt_b3_last", 32'(ol[1]), 1);
`else
    chk("pkt_b3_valid", 32'(ov), 32'b0001);
    chk("pkt_b3_data", 32'(od[7:0]), 8'h03);
    chk("pkt_b3_last", 32'(ol[0]), 1);
`endif
    sel = 2; d = 8'h04; l = 1;
    tick();
    chk("single_valid", 32'(ov), 32'b0100);
    chk("single_data", 32'(od[23:16]), 8'h04);
    v = 0;
    tick();
    chk("pkt_drained", 32'(ov), 0);

    v3 = 1; sel3 = 3; d3 = 8'h55; l3 = 1; rdy3 = 0;
    #1 chk("oor_in_ready", 32'(irdy3), 1);
    tick();
    v3 = 0;
    chk("oor_drop", 32'(de3), 1);
    chk("oor_valid", 32'(ov3), 0);
    tick();
    chk("oor_drop_pulse", 32'(de3), 0);
    chk("oor_valid_after", 32'(ov3), 0);
    v3 = 1; sel3 = 1; d3 = 8'h56;
    tick();
    v3 = 0;
    chk("n3_route_valid", 32'(ov3), 32'b010);
    chk("n3_route_data", 32'(od3[15:8]), 8'h56);
    chk("n3_route_drop", 32'(de3), 0);

    do_reset();
    for (int k = 0; k < 4; k++) begin mv[k] = 0; md[k] = 0; ml[k] = 0; end
    locked = 0; lsel = 0;
    for (int c = 0; c < 400; c++) begin
      logic [1:0] es;
      logic er, acc;
      v = 1'($urandom_range(0, 3) != 0);
      sel = 2'($urandom);
      d = 8'($urandom);
      l = 1'($urandom_range(0, 2) == 0);
      rdy = 4'($urandom);
      es = locked ? lsel : sel;
      er = !mv[es] || rdy[es];
      acc = v && er;
      #1 chk("rnd_in_ready", 32'(irdy), 32'(er));
      tick();
      for (int k = 0; k < 4; k++) begin
        if (acc && es == 2'(k)) begin mv[k] = 1; md[k] = d; ml[k] = l; end
        else if (mv[k] && rdy[k]) mv[k] = 0;
      end
`ifdef DMUX_PKT_LOCK_EN
      if (acc) begin
        if (!locked && !l) begin locked = 1; lsel = sel; end
        else if (locked && l) locked = 0;
      end
`endif
      for (int k = 0; k < 4; k++) begin
        chk("rnd_valid", 32'(ov[k]), 32'(mv[k]));
        if (mv[k]) begin
          chk("rnd_data", 32'(od[k*8 +: 8]), 32'(md[k]));
          chk("rnd_last", 32'(ol[k]), 32'(ml[k]));
        end
      end
      chk("rnd_drop", 32'(de), 0);
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
